// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared constants and helpers for the motor speed front end
package motor_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  function automatic int gate_clocks(input int clk_hz, input int gate_hz);
    return clk_hz / gate_hz;
  endfunction

  // 4x decode of previous vs current {A, B}; both bits moving at once is illegal
  function automatic step_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return STEP_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: return STEP_ERR;
      default:                            return STEP_NONE;
    endcase
  endfunction

  function automatic int sat_add(input int acc, input step_e step, input int lim);
    int sum;
    sum = acc;
    if (step == STEP_FWD) sum = acc + 1;
    else if (step == STEP_REV) sum = acc - 1;
    if (sum > lim) sum = lim;
    else if (sum < -lim) sum = -lim;
    return sum;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - 2-FF synchronizer plus minimum-width level filter
module quad_glitch_filter #(
  parameter int MINPW_CYC = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = (MINPW_CYC > 1) ? $clog2(MINPW_CYC) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is taken only after it has differed from filt for MINPW_CYC samples
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(MINPW_CYC - 1)) filt_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_gate_counter.sv
// rtl/quad_gate_counter.sv - quadrature decode and gated signed edge counter
module quad_gate_counter
  import motor_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int GATE_HZ   = 200,
  parameter int MINPW_CYC = 50,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    enc_a_in,
  input  logic                    enc_b_in,
  output logic signed [CNT_W-1:0] spdcnt,
  output logic                    cnt_valid,
  output logic                    dir_out,
  output logic                    gate_err
);

  localparam int GATE_CLOCKS = gate_clocks(CLK_HZ, GATE_HZ);
  localparam int GW          = (GATE_CLOCKS > 1) ? $clog2(GATE_CLOCKS) : 1;
  localparam int LIM         = (2 ** (CNT_W - 1)) - 1;

  logic                    filt_a, filt_b;
  logic [1:0]              prev_q;
  logic [GW-1:0]           gate_ctr_q, gate_ctr_d;
  logic signed [CNT_W-1:0] acc_q, acc_d, spdcnt_q, spdcnt_d;
  logic                    win_err_q, win_err_d;
  logic                    valid_q, valid_d, dir_q, dir_d, err_q, err_d;
  logic                    terminal;
  step_e                   step;
  int                      sum;

  quad_glitch_filter #(.MINPW_CYC(MINPW_CYC)) u_filt_a (
    .clk_i (aclk),
    .rst_i (rst),
    .raw_i (enc_a_in),
    .filt_o(filt_a)
  );

  quad_glitch_filter #(.MINPW_CYC(MINPW_CYC)) u_filt_b (
    .clk_i (aclk),
    .rst_i (rst),
    .raw_i (enc_b_in),
    .filt_o(filt_b)
  );

  // The terminal cycle's own step belongs to the window being closed
  always_comb begin
    step       = quad_decode(prev_q, {filt_a, filt_b});
    sum        = sat_add(int'(acc_q), step, LIM);
    terminal   = (gate_ctr_q == GW'(GATE_CLOCKS - 1));
    gate_ctr_d = terminal ? '0 : gate_ctr_q + 1'b1;
    acc_d      = CNT_W'(sum);
    win_err_d  = win_err_q | (step == STEP_ERR);
    spdcnt_d   = spdcnt_q;
    dir_d      = dir_q;
    err_d      = err_q;
    valid_d    = terminal;
    if (terminal) begin
      spdcnt_d  = CNT_W'(sum);
      dir_d     = (sum >= 0);
      err_d     = win_err_d;
      acc_d     = '0;
      win_err_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      prev_q     <= 2'b00;
      gate_ctr_q <= '0;
      acc_q      <= '0;
      win_err_q  <= 1'b0;
      spdcnt_q   <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= {filt_a, filt_b};
      gate_ctr_q <= gate_ctr_d;
      acc_q      <= acc_d;
      win_err_q  <= win_err_d;
      spdcnt_q   <= spdcnt_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign spdcnt    = spdcnt_q;
  assign cnt_valid = valid_q;
  assign dir_out   = dir_q;
  assign gate_err  = err_q;

endmodule

// File: tb/tb_quad_gate_counter.sv
// tb/tb_quad_gate_counter.sv - scoreboard bench for quad_gate_counter
module tb_quad_gate_counter;

  localparam int G  = 6000;
  localparam int GS = 11000;
  localparam int SP = 54;

  typedef struct {
    int   cnt;
    logic dir;
    logic err;
  } exp_t;

  logic              aclk = 1'b0;
  logic              rst = 1'b1;
  logic              enc_a = 1'b0;
  logic              enc_b = 1'b0;
  logic signed [15:0] spdcnt;
  logic              cnt_valid, dir_out, gate_err;
  logic signed [7:0] s_spdcnt;
  logic              s_valid, s_dir, s_err;
  exp_t              sb[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                cyc = 0;
  int                pos = 0;
  logic [1:0]        seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  quad_gate_counter #(.CLK_HZ(G), .GATE_HZ(1)) u_dut (
    .aclk(aclk), .rst(rst), .enc_a_in(enc_a), .enc_b_in(enc_b),
    .spdcnt(spdcnt), .cnt_valid(cnt_valid), .dir_out(dir_out), .gate_err(gate_err)
  );

  quad_gate_counter #(.CLK_HZ(GS), .GATE_HZ(1), .CNT_W(8)) u_sat (
    .aclk(aclk), .rst(rst), .enc_a_in(enc_a), .enc_b_in(enc_b),
    .spdcnt(s_spdcnt), .cnt_valid(s_valid), .dir_out(s_dir), .gate_err(s_err)
  );

  function automatic exp_t mk(input int c, input logic d, input logic er);
    exp_t e;
    e.cnt = c;
    e.dir = d;
    e.err = er;
    return e;
  endfunction

  task automatic step_enc(input bit fwd, input int n);
    for (int i = 0; i < n; i++) begin
      pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
      {enc_a, enc_b} = seq[pos[1:0]];
      repeat (SP) @(negedge aclk);
    end
  endtask

  task automatic wait_valid(input bit sat, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge aclk);
      ok = sat ? s_valid : cnt_valid;
    end
  endtask

  task automatic test_reset();
    bit ok;
    exp_t e;
    int rel;
    rst = 1'b1;
    {enc_a, enc_b} = 2'b00;
    pos = 0;
    repeat (5) @(negedge aclk);
    n_checks++;
    if (spdcnt !== 16'sd0 || cnt_valid !== 1'b0 || dir_out !== 1'b1 || gate_err !== 1'b0)
      $display("FAIL reset_values: got cnt=%0d valid=%0b dir=%0b err=%0b want 0 0 1 0", spdcnt, cnt_valid, dir_out, gate_err);
    else n_pass++;
    sb.push_back(mk(0, 1'b1, 1'b0));
    rst = 1'b0;
    rel = cyc;
    wait_valid(1'b0, G + 10, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc - rel != G) $display("FAIL first_valid_cycle: got %0d want %0d", ok ? cyc - rel : -1, G);
    else n_pass++;
    n_checks++;
    if (int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL idle_report: got cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
    @(negedge aclk);
    n_checks++;
    if (cnt_valid !== 1'b0) $display("FAIL valid_width: got %0b want 0 one cycle after pulse", cnt_valid);
    else n_pass++;
  endtask

  task automatic test_glitch();
    bit ok, moved, rose_a, rose_b;
    exp_t e;
    sb.push_back(mk(0, 1'b1, 1'b0));
    moved = 1'b0;
    for (int i = 0; i < 200; i++) begin
      enc_a = (i < 30);
      enc_b = (i >= 80 && i < 129);
      @(negedge aclk);
      if (u_dut.filt_a !== 1'b0 || u_dut.filt_b !== 1'b0) moved = 1'b1;
    end
    n_checks++;
    if (moved !== 1'b0) $display("FAIL glitch_short: got filt change=%0b want 0 for 30/49-cycle pulses", moved);
    else n_pass++;
    rose_a = 1'b0;
    rose_b = 1'b0;
    for (int i = 0; i < 260; i++) begin
      enc_a = (i < 60);
      enc_b = (i >= 80 && i < 130);
      @(negedge aclk);
      if (u_dut.filt_a === 1'b1) rose_a = 1'b1;
      if (u_dut.filt_b === 1'b1) rose_b = 1'b1;
    end
    n_checks++;
    if (rose_a !== 1'b1 || rose_b !== 1'b1)
      $display("FAIL glitch_accept: got rise a=%0b b=%0b want 1 1 for 60/50-cycle pulses", rose_a, rose_b);
    else n_pass++;
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL glitch_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_forward();
    bit ok;
    exp_t e;
    sb.push_back(mk(100, 1'b1, 1'b0));
    step_enc(1'b1, 100);
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL fwd_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
    sb.push_back(mk(0, 1'b1, 1'b0));
    wait_valid(1'b0, G + 10, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL fwd_idle_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_reverse();
    bit ok;
    exp_t e;
    sb.push_back(mk(-37, 1'b0, 1'b0));
    step_enc(1'b0, 37);
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL rev_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok;
    exp_t e;
    sb.push_back(mk(4, 1'b1, 1'b1));
    step_enc(1'b1, 4);
    {enc_a, enc_b} = ~{enc_a, enc_b};
    repeat (100) @(negedge aclk);
    {enc_a, enc_b} = ~{enc_a, enc_b};
    repeat (SP + 10) @(negedge aclk);
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL illegal_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_terminal();
    bit ok;
    exp_t e;
    // update lands on the terminal edge: closing window, which is also the clean gate after the error
    sb.push_back(mk(1, 1'b1, 1'b0));
    repeat (G - 53) @(negedge aclk);
    pos = (pos + 1) % 4;
    {enc_a, enc_b} = seq[pos[1:0]];
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL term_on_edge: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
    // update lands one cycle after the terminal edge: next window
    sb.push_back(mk(0, 1'b1, 1'b0));
    sb.push_back(mk(1, 1'b1, 1'b0));
    repeat (G - 52) @(negedge aclk);
    pos = (pos + 1) % 4;
    {enc_a, enc_b} = seq[pos[1:0]];
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL term_late_old: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
    wait_valid(1'b0, G + 10, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL term_late_new: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    int rel;
    while (pos != 0) step_enc(1'b1, 1);
    step_enc(1'b1, 20);
    rst = 1'b1;
    repeat (3) @(negedge aclk);
    rst = 1'b0;
    rel = cyc;
    sb.push_back(mk(8, 1'b1, 1'b0));
    step_enc(1'b1, 8);
    wait_valid(1'b0, G, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc - rel != G) $display("FAIL reset_mid_timing: got %0d want %0d", ok ? cyc - rel : -1, G);
    else n_pass++;
    n_checks++;
    if (int'(spdcnt) !== e.cnt || dir_out !== e.dir || gate_err !== e.err)
      $display("FAIL reset_mid_report: got cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", spdcnt, dir_out, gate_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  task automatic test_saturate();
    bit ok;
    exp_t e;
    rst = 1'b1;
    repeat (3) @(negedge aclk);
    rst = 1'b0;
    sb.push_back(mk(127, 1'b1, 1'b0));
    step_enc(1'b1, 200);
    wait_valid(1'b1, GS, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(s_spdcnt) !== e.cnt || s_dir !== e.dir || s_err !== e.err)
      $display("FAIL sat_report: got ok=%0b cnt=%0d dir=%0b err=%0b want cnt=%0d dir=%0b err=%0b", ok, s_spdcnt, s_dir, s_err, e.cnt, e.dir, e.err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_forward();
    test_reverse();
    test_illegal();
    test_terminal();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
